// File: rtl/fe_invert.sv
// rtl/fe_invert.sv - Fermat field inversion mod 2^255-19 driving an owned femul multiplier

// femul: one-cycle modular multiply mod 2^255-19. It has no reset, so a done
// pulse may appear after reset for an op that was in flight.
module femul (
   input  logic         clk_i,
   input  logic         start_i,
   input  logic [254:0] a_i,
   input  logic [254:0] b_i,
   output logic         done_o,
   output logic [254:0] out_o
);

   logic [509:0] prod;
   logic [259:0] fold1;
   logic [255:0] fold2;
   logic [254:0] fold3;
   logic         done_q;
   logic [254:0] out_q;

   // Full product, then fold twice using 2^255 == 19; the result is < 2^255 but may exceed P
   always_comb begin
      prod  = {255'd0, a_i} * {255'd0, b_i};
      fold1 = {5'd0, prod[254:0]} + (260'(prod[509:255]) * 260'd19);
      fold2 = {1'b0, fold1[254:0]} + (256'(fold1[259:255]) * 256'd19);
      fold3 = fold2[255] ? (fold2[254:0] + 255'd19) : fold2[254:0];
   end

   // Register the product; done follows start by one cycle
   always_ff @(posedge clk_i) begin
      done_q <= start_i;
      if (start_i) begin
         out_q <= fold3;
      end
   end

   assign done_o = done_q;
   assign out_o  = out_q;

endmodule

// fe_invert: out = a^EXP through a left-to-right square-and-multiply chain on femul
module fe_invert #(
   parameter int               EBITS = 255,
   parameter logic [EBITS-1:0] EXP   = {{(EBITS-5){1'b1}}, 5'b01011},
   parameter int               DRAIN = 40
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         start_i,
   input  logic [254:0] a_in_i,
   output logic         busy_o,
   output logic         done_o,
   output logic [254:0] out_o
);

   localparam int             BIT_W   = $clog2(EBITS);
   localparam logic [BIT_W-1:0] BIT_TOP = BIT_W'(EBITS - 2);
   localparam int             DCNT_W  = (DRAIN > 1) ? $clog2(DRAIN) : 1;
   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DRAIN - 1);

   typedef enum logic [2:0] {
      ST_DRAIN   = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SQ_GO   = 3'd2,
      ST_SQ_WAIT = 3'd3,
      ST_MU_GO   = 3'd4,
      ST_MU_WAIT = 3'd5,
      ST_NEXT    = 3'd6,
      ST_FIN     = 3'd7
   } state_t;

   state_t              state_q;
   logic                busy_q;
   logic                done_q;
   logic [254:0]        out_q;
   logic [254:0]        acc_q;
   logic [254:0]        base_q;
   logic [BIT_W-1:0]    bit_q;
   logic [DCNT_W-1:0]   drain_q;

   logic                fm_start;
   logic [254:0]        fm_b;
   logic                fm_done;
   logic [254:0]        fm_out;

   // Operand b is base for the whole multiply op and acc for squarings, so it is stable until done
   always_comb begin
      fm_start = (state_q == ST_SQ_GO) || (state_q == ST_MU_GO);
      fm_b     = ((state_q == ST_MU_GO) || (state_q == ST_MU_WAIT)) ? base_q : acc_q;
   end

   femul u_femul (
      .clk_i  (clk_i),
      .start_i(fm_start),
      .a_i    (acc_q),
      .b_i    (fm_b),
      .done_o (fm_done),
      .out_o  (fm_out)
   );

   // Sequencer: drain stale femul activity after reset, then one square (+ optional multiply) per exponent bit
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_DRAIN;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
         out_q   <= '0;
         acc_q   <= '0;
         base_q  <= '0;
         bit_q   <= BIT_TOP;
         drain_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_DRAIN: begin
               if (drain_q == DCNT_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  drain_q <= drain_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (start_i) begin
                  base_q  <= a_in_i;
                  acc_q   <= a_in_i;
                  bit_q   <= BIT_TOP;
                  state_q <= ST_SQ_GO;
                  busy_q  <= 1'b1;
               end
            end
            ST_SQ_GO: begin
               state_q <= ST_SQ_WAIT;
            end
            ST_SQ_WAIT: begin
               if (fm_done) begin
                  acc_q   <= fm_out;
                  state_q <= EXP[bit_q] ? ST_MU_GO : ST_NEXT;
               end
            end
            ST_MU_GO: begin
               state_q <= ST_MU_WAIT;
            end
            ST_MU_WAIT: begin
               if (fm_done) begin
                  acc_q   <= fm_out;
                  state_q <= ST_NEXT;
               end
            end
            ST_NEXT: begin
               if (bit_q == '0) begin
                  state_q <= ST_FIN;
               end else begin
                  bit_q   <= bit_q - 1'b1;
                  state_q <= ST_SQ_GO;
               end
            end
            ST_FIN: begin
               out_q   <= acc_q;
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_DRAIN;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign out_o  = out_q;

endmodule

// File: tb/tb_fe_invert.sv
// tb/tb_fe_invert.sv - randomized self-checking bench for fe_invert against modular arithmetic

module tb_fe_invert;

   localparam int EBITS = 255;
   localparam int DRAIN = 40;
   localparam int NOPS  = 506;
   localparam int LIMIT = 4000;
   localparam logic [511:0] P = (512'd1 << 255) - 512'd19;

   logic         clk_i   = 1'b0;
   logic         rst_ni  = 1'b0;
   logic         start_i = 1'b0;
   logic [254:0] a_in_i  = '0;
   logic         busy_o;
   logic         done_o;
   logic [254:0] out_o;

   int n_checks  = 0;
   int n_fail    = 0;
   int fm_starts = 0;
   int done_cnt  = 0;

   fe_invert #(.EBITS(EBITS), .DRAIN(DRAIN)) dut (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .start_i(start_i),
      .a_in_i (a_in_i),
      .busy_o (busy_o),
      .done_o (done_o),
      .out_o  (out_o)
   );

   always #5 clk_i = ~clk_i;

   // Count multiplier requests and done pulses, sampled mid-cycle
   always @(negedge clk_i) begin
      if (dut.fm_start) fm_starts++;
      if (done_o) done_cnt++;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] mulmod(input logic [254:0] x, input logic [254:0] y);
      logic [511:0] p;
      p = {257'd0, x} * {257'd0, y};
      p = p % P;
      return p[255:0];
   endfunction

   function automatic logic [255:0] modp(input logic [254:0] x);
      logic [511:0] p;
      p = {257'd0, x} % P;
      return p[255:0];
   endfunction

   function automatic logic [254:0] rand_val();
      logic [255:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom;
      return r[254:0];
   endfunction

   // Issue one request and wait for done; optionally poke a second start while busy
   task automatic run_inv(input logic [254:0] a, input bit now, input int poke_at,
                          input logic [254:0] poke_val, output logic [254:0] res,
                          output int starts, output int gaps, output bit timed_out);
      int s0;
      if (!now) @(negedge clk_i);
      s0 = fm_starts;
      a_in_i  = a;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      gaps = 0;
      timed_out = 1'b1;
      for (int n = 0; n < LIMIT; n++) begin
         if (done_o) begin
            timed_out = 1'b0;
            break;
         end
         if (!busy_o) gaps++;
         start_i = (n == poke_at);
         if (n == poke_at) a_in_i = poke_val;
         @(negedge clk_i);
         start_i = 1'b0;
      end
      res = out_o;
      starts = fm_starts - s0;
   endtask

   logic [254:0] a, res;
   int st, gaps, d0, s0;
   bit to;

   initial begin
      // Reset state
      rst_ni = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_busy", 256'(busy_o), 256'(1));
      check("rst_done", 256'(done_o), 256'(0));
      check("rst_out", 256'(out_o), 256'(0));
      rst_ni = 1'b1;
      repeat (DRAIN + 2) @(negedge clk_i);
      check("idle_busy", 256'(busy_o), 256'(0));

      // a = 1
      d0 = done_cnt;
      run_inv(255'd1, 1'b0, -1, '0, res, st, gaps, to);
      check("t1_timeout", 256'(to), 256'(0));
      check("t1_modp", modp(res), 256'(1));
      check("t1_starts", 256'(st), 256'(NOPS));
      check("t1_busy_gaps", 256'(gaps), 256'(0));
      check("t1_busy_at_done", 256'(busy_o), 256'(0));
      @(negedge clk_i);
      check("t1_done_single", 256'(done_o), 256'(0));
      check("t1_done_count", 256'(done_cnt - d0), 256'(1));

      // a = 2, inverse is 2^254-9
      run_inv(255'd2, 1'b0, -1, '0, res, st, gaps, to);
      check("t2_timeout", 256'(to), 256'(0));
      check("t2_inv2", modp(res), (256'd1 << 254) - 256'd9);

      // a = 0 stays 0 with normal op count
      run_inv(255'd0, 1'b1, -1, '0, res, st, gaps, to);
      check("t3_timeout", 256'(to), 256'(0));
      check("t3_zero", 256'(res), 256'(0));
      check("t3_starts", 256'(st), 256'(NOPS));

      // Random operands, every sixth one >= P; odd iterations restart in the done cycle
      for (int i = 0; i < 24; i++) begin
         a = (i % 6 == 0) ? 255'(P[254:0] + 255'($urandom_range(0, 18))) : rand_val();
         run_inv(a, (i % 2) == 1, -1, '0, res, st, gaps, to);
         check("t4_timeout", 256'(to), 256'(0));
         check("t4_starts", 256'(st), 256'(NOPS));
         if (modp(a) == 256'(0)) check("t4_zero_class", modp(res), 256'(0));
         else check("t4_inverse", mulmod(res, a), 256'(1));
      end

      // Start while busy is dropped
      run_inv(255'd5, 1'b0, 50, 255'd7, res, st, gaps, to);
      check("t5_timeout", 256'(to), 256'(0));
      check("t5_starts", 256'(st), 256'(NOPS));
      check("t5_inverse", mulmod(res, 255'd5), 256'(1));
      @(negedge clk_i);
      check("t5_idle_after", 256'(busy_o), 256'(0));

      // Start during drain is dropped
      rst_ni = 1'b0;
      @(negedge clk_i);
      rst_ni = 1'b1;
      s0 = fm_starts;
      repeat (5) @(negedge clk_i);
      a_in_i = 255'd9;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (DRAIN) @(negedge clk_i);
      check("t5_drain_starts", 256'(fm_starts - s0), 256'(0));
      check("t5_drain_idle", 256'(busy_o), 256'(0));

      // Leave a nonzero result in out before the abort
      a = rand_val();
      run_inv(a, 1'b0, -1, '0, res, st, gaps, to);
      check("t6_pre_inverse", mulmod(res, a), 256'(1));

      // Reset at about the 100th femul start
      @(negedge clk_i);
      s0 = fm_starts;
      a_in_i = rand_val();
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      to = 1'b1;
      for (int n = 0; n < LIMIT; n++) begin
         if (fm_starts - s0 >= 100) begin
            to = 1'b0;
            break;
         end
         @(negedge clk_i);
      end
      check("t6_reach_100", 256'(to), 256'(0));
      rst_ni = 1'b0;
      #1;
      check("t6_abort_busy", 256'(busy_o), 256'(1));
      check("t6_abort_done", 256'(done_o), 256'(0));
      check("t6_abort_out", 256'(out_o), 256'(0));
      repeat (2) @(negedge clk_i);
      d0 = done_cnt;
      s0 = fm_starts;
      rst_ni = 1'b1;
      repeat (DRAIN - 2) @(negedge clk_i);
      check("t6_drain_busy", 256'(busy_o), 256'(1));
      a_in_i = 255'd13;
      start_i = 1'b1;
      @(negedge clk_i);
      start_i = 1'b0;
      @(negedge clk_i);
      run_inv(255'd3, 1'b1, -1, '0, res, st, gaps, to);
      check("t6_timeout", 256'(to), 256'(0));
      check("t6_inverse3", mulmod(res, 255'd3), 256'(1));
      check("t6_starts", 256'(fm_starts - s0), 256'(NOPS));
      @(negedge clk_i);
      check("t6_done_count", 256'(done_cnt - d0), 256'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
